// File: rtl/dmem_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-memory AXI bridge.
// Optional response-error reporting is enabled by DMEM_BRIDGE_ERR_EN.
package dmem_axi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_AR   = 3'd1,
        S_RD_R    = 3'd2,
        S_WR_AW_W = 3'd3,
        S_WR_B    = 3'd4,
        S_DONE    = 3'd5
    } stateT;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic isRespErr(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/dmem_axi_bridge_if.sv
// AXI4 master-side bundle used by the data-memory bridge.
// Master drives requests; slave drives ready/response signals.
interface dmem_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/dmem_axi_bridge_axi_wr_chan.sv
// Write address/data valid tracking: both raise together,
// each drops on its own handshake.
module axi_wr_chan (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic awReady,
    input  logic wReady,
    output logic awValid,
    output logic wValid,
    output logic done
);

    logic awDone;
    logic wDone;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awValid <= 1'b0;
            wValid  <= 1'b0;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
        end else if (start) begin
            awValid <= 1'b1;
            wValid  <= 1'b1;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
        end else begin
            if (awValid && awReady) begin
                awValid <= 1'b0;
                awDone  <= 1'b1;
            end
            if (wValid && wReady) begin
                wValid <= 1'b0;
                wDone  <= 1'b1;
            end
        end
    end

    // Counts a handshake happening this cycle so WR_B follows immediately.
    assign done = (awDone || (awValid && awReady))
               && (wDone || (wValid && wReady));

endmodule

// File: rtl/dmem_axi_bridge.sv
// MEM-stage load/store to single-beat AXI4 bridge with pipeline stall.
// Define DMEM_BRIDGE_ERR_EN to report SLVERR/DECERR on bus_err.
module dmem_axi_bridge
    import dmem_axi_bridge_pkg::*;
#(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memenM,
    input  logic                memwriteM,
    input  logic [ADDR_W-1:0]   addrM,
    input  logic [DATA_W-1:0]   wdataM,
    input  logic [DATA_W/8-1:0] wstrbM,
    input  logic [1:0]          sizeM,
    output logic [DATA_W-1:0]   rdataM,
    output logic                mem_stall,
    output logic                bus_err,
    dmem_axi_bridge_if.master   axi
);

    stateT                state;
    logic [ADDR_W-1:0]    addrQ;
    logic [DATA_W-1:0]    wdataQ;
    logic [DATA_W/8-1:0]  wstrbQ;
    logic [1:0]           sizeQ;
    logic                 writeQ;
    logic                 arValid;
    logic                 rReady;
    logic                 bReady;
    logic                 wrStart;
    logic                 wrDone;
    logic                 awValid;
    logic                 wValid;

    assign wrStart = (state == S_IDLE) && memenM && memwriteM;

    axi_wr_chan uWrChan (
        .clk     (clk),
        .rst     (rst),
        .start   (wrStart),
        .awReady (axi.awready),
        .wReady  (axi.wready),
        .awValid (awValid),
        .wValid  (wValid),
        .done    (wrDone)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            addrQ   <= '0;
            wdataQ  <= '0;
            wstrbQ  <= '0;
            sizeQ   <= '0;
            writeQ  <= 1'b0;
            arValid <= 1'b0;
            rReady  <= 1'b0;
            bReady  <= 1'b0;
            rdataM  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (memenM) begin
                        addrQ   <= addrM;
                        wdataQ  <= wdataM;
                        wstrbQ  <= wstrbM;
                        sizeQ   <= sizeM;
                        writeQ  <= memwriteM;
                        arValid <= !memwriteM;
                        state   <= memwriteM ? S_WR_AW_W : S_RD_AR;
                    end
                end
                S_RD_AR: begin
                    if (axi.arready) begin
                        arValid <= 1'b0;
                        rReady  <= 1'b1;
                        state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (axi.rvalid) begin
                        rdataM <= axi.rdata;
                        rReady <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_WR_AW_W: begin
                    if (wrDone) begin
                        bReady <= 1'b1;
                        state  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (axi.bvalid) begin
                        bReady <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                // The pipeline advances here; the next request is seen in IDLE.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_stall = (state == S_IDLE) ? memenM : (state != S_DONE);

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addrQ;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, sizeQ};
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = arValid;
    assign axi.rready  = rReady;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addrQ;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, sizeQ};
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = awValid;

    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdataQ;
    assign axi.wstrb   = wstrbQ;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wValid;
    assign axi.bready  = bReady;

`ifdef DMEM_BRIDGE_ERR_EN
    logic errQ;
    logic unusedSigs;

    // Set on the response handshake, so it is high only during DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errQ <= 1'b0;
        end else begin
            errQ <= ((state == S_RD_R) && axi.rvalid && isRespErr(axi.rresp))
                 || ((state == S_WR_B) && axi.bvalid && isRespErr(axi.bresp));
        end
    end

    assign bus_err    = errQ;
    assign unusedSigs = ^{axi.rid, axi.rlast, axi.bid, writeQ};
`else
    logic unusedSigs;

    assign bus_err    = 1'b0;
    assign unusedSigs = ^{axi.rid, axi.rlast, axi.bid,
                          axi.rresp, axi.bresp, writeQ};
`endif

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Self-checking bench for dmem_axi_bridge with a delay-programmable AXI slave.
// Expected bus_err follows DMEM_BRIDGE_ERR_EN when the bench is built.
module tb_dmem_axi_bridge;
    import dmem_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memenM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [31:0] addrM = '0;
    logic [31:0] wdataM = '0;
    logic [3:0]  wstrbM = '0;
    logic [1:0]  sizeM = '0;
    logic [31:0] rdataM;
    logic        mem_stall;
    logic        bus_err;

    int checks = 0;
    int failures = 0;

    dmem_axi_bridge_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

    dmem_axi_bridge #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .AXI_ID(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .addrM(addrM), .wdataM(wdataM), .wstrbM(wstrbM), .sizeM(sizeM),
        .rdataM(rdataM), .mem_stall(mem_stall), .bus_err(bus_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  size;
        int          arW, rW, awW, wW, bW;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } reqT;

    typedef struct {
        reqT r;
        int  expStall;
    } vecT;

    // Slave knobs: cycles each valid waits before ready / response.
    int          arW = 0, rW = 0, awW = 0, wW = 0, bW = 0;
    logic [31:0] rdataV = '0;
    logic [1:0]  respV = '0;
    int          arC = 0, rC = 0, awC = 0, wC = 0, bC = 0;

    // Monitor results
    int          arCnt = 0, awCnt = 0, protErr = 0, stabErr = 0;
    logic [31:0] lastAr = '0, lastAw = '0, lastWd = '0;
    logic [3:0]  lastWs = '0;
    logic [2:0]  lastArSz = '0, lastAwSz = '0;
    bit          pendR = 0, pendB = 0, awSeen = 0, wSeen = 0;
    bit          pArv = 0, pArr = 0, pAwv = 0, pAwr = 0, pWv = 0, pWr = 0;
    logic [31:0] pAra = '0, pAwa = '0, pWd = '0;
    logic [31:0] modelRd = '0;

    always @(negedge clk) begin
        if (!rst) begin
            axi.arready = 0; axi.awready = 0; axi.wready = 0;
            axi.rvalid = 0; axi.bvalid = 0;
            axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
            axi.bid = 0; axi.bresp = 0;
            arC = 0; rC = 0; awC = 0; wC = 0; bC = 0;
        end else begin
            if (axi.arvalid) begin axi.arready = (arC >= arW); arC++; end
            else begin axi.arready = 0; arC = 0; end
            if (axi.awvalid) begin axi.awready = (awC >= awW); awC++; end
            else begin axi.awready = 0; awC = 0; end
            if (axi.wvalid) begin axi.wready = (wC >= wW); wC++; end
            else begin axi.wready = 0; wC = 0; end
            if (pendR) begin
                axi.rvalid = (rC >= rW); rC++;
                axi.rdata = rdataV; axi.rresp = respV;
                axi.rlast = 1; axi.rid = 4'd1;
            end else begin axi.rvalid = 0; rC = 0; end
            if (pendB) begin
                axi.bvalid = (bC >= bW); bC++;
                axi.bresp = respV; axi.bid = 4'd1;
            end else begin axi.bvalid = 0; bC = 0; end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            pendR = 0; pendB = 0; awSeen = 0; wSeen = 0;
            pArv = 0; pAwv = 0; pWv = 0;
        end else begin
            if (pArv && !pArr && (!axi.arvalid || axi.araddr !== pAra)) stabErr++;
            if (pAwv && !pAwr && (!axi.awvalid || axi.awaddr !== pAwa)) stabErr++;
            if (pWv && !pWr && (!axi.wvalid || axi.wdata !== pWd)) stabErr++;
            pArv = axi.arvalid; pArr = axi.arready; pAra = axi.araddr;
            pAwv = axi.awvalid; pAwr = axi.awready; pAwa = axi.awaddr;
            pWv = axi.wvalid; pWr = axi.wready; pWd = axi.wdata;
            if (axi.arvalid && axi.arready) begin
                arCnt++; lastAr = axi.araddr; lastArSz = axi.arsize; pendR = 1;
                if (axi.arlen != 0 || axi.arburst != BURST_INCR || axi.arid != 4'd1)
                    protErr++;
            end
            if (axi.rvalid && axi.rready) pendR = 0;
            if (axi.awvalid && axi.awready) begin
                awCnt++; lastAw = axi.awaddr; lastAwSz = axi.awsize; awSeen = 1;
                if (axi.awlen != 0 || axi.awburst != BURST_INCR || axi.awid != 4'd1)
                    protErr++;
            end
            if (axi.wvalid && axi.wready) begin
                lastWd = axi.wdata; lastWs = axi.wstrb; wSeen = 1;
                if (axi.wlast != 1'b1 || axi.wid != 4'd1) protErr++;
            end
            if (axi.bvalid && axi.bready) pendB = 0;
            if (awSeen && wSeen) begin pendB = 1; awSeen = 0; wSeen = 0; end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic reqT mk(bit wr, logic [31:0] a, logic [31:0] d,
                               logic [3:0] s, logic [1:0] sz, int aW, int r_W,
                               int awWt, int wWt, int bWt, logic [31:0] rd,
                               logic [1:0] rsp);
        reqT q;
        q.wr = wr; q.addr = a; q.wdata = d; q.strb = s; q.size = sz;
        q.arW = aW; q.rW = r_W; q.awW = awWt; q.wW = wWt; q.bW = bWt;
        q.rdata = rd; q.resp = rsp;
        return q;
    endfunction

    function automatic bit expErr(reqT q);
`ifdef DMEM_BRIDGE_ERR_EN
        return q.resp == RESP_SLVERR || q.resp == RESP_DECERR;
`else
        return (q.resp === 2'bxx);
`endif
    endfunction

    // Cycles with stall high = request cycle + address phase + response phase.
    function automatic int modelStall(reqT q);
        int aw;
        aw = (q.awW > q.wW) ? q.awW : q.wW;
        return q.wr ? (3 + aw + q.bW) : (3 + q.arW + q.rW);
    endfunction

    task automatic runReq(input reqT q, input bit keep, input bit perturb,
                          output int stalls, output bit errEarly,
                          output bit errDone, output bit addrBad);
        @(negedge clk);
        arW = q.arW; rW = q.rW; awW = q.awW; wW = q.wW; bW = q.bW;
        rdataV = q.rdata; respV = q.resp;
        memenM = 1; memwriteM = q.wr; addrM = q.addr;
        wdataM = q.wdata; wstrbM = q.strb; sizeM = q.size;
        #1;
        stalls = 0; errEarly = 0; addrBad = 0;
        while (mem_stall && stalls < 200) begin
            stalls++;
            if (bus_err) errEarly = 1;
            @(negedge clk);
            if (perturb) begin
                addrM = $urandom; wdataM = $urandom;
                wstrbM = 4'($urandom); sizeM = 2'($urandom_range(0, 2));
                memwriteM = 1'($urandom);
            end
            #1;
            if ((axi.arvalid && axi.araddr !== q.addr) ||
                (axi.awvalid && axi.awaddr !== q.addr)) addrBad = 1;
        end
        errDone = bus_err;
        if (!keep) memenM = 0;
    endtask

    task automatic doAndVerify(input string tag, input reqT q, input int expStall,
                               input bit keep);
        int  arB, awB, st;
        bit  eE, eD, bad;
        arB = arCnt; awB = awCnt;
        runReq(q, keep, 1'b1, st, eE, eD, bad);
        check({tag, " stall"}, 32'(st), 32'(expStall));
        if (q.wr) begin
            check({tag, " txns"}, 32'((arCnt - arB) * 16 + (awCnt - awB)), 32'd1);
            check({tag, " awaddr"}, lastAw, q.addr);
            check({tag, " awsize"}, 32'(lastAwSz), 32'({1'b0, q.size}));
            check({tag, " wdata"}, lastWd, q.wdata);
            check({tag, " wstrb"}, 32'(lastWs), 32'(q.strb));
        end else begin
            modelRd = q.rdata;
            check({tag, " txns"}, 32'((arCnt - arB) * 16 + (awCnt - awB)), 32'd16);
            check({tag, " araddr"}, lastAr, q.addr);
            check({tag, " arsize"}, 32'(lastArSz), 32'({1'b0, q.size}));
        end
        check({tag, " rdataM"}, rdataM, modelRd);
        check({tag, " bus_err done"}, 32'(eD), 32'(expErr(q)));
        check({tag, " bus_err early"}, 32'(eE), 32'd0);
        check({tag, " addr stable"}, 32'(bad), 32'd0);
    endtask

    vecT tbl[7];

    initial begin
        tbl[0] = '{r: mk(0, 32'h0000_1004, 0, 0, SIZE_WORD, 0, 0, 0, 0, 0,
                         32'hDEAD_BEEF, RESP_OKAY), expStall: 3};
        tbl[1] = '{r: mk(1, 32'h0000_2000, 32'h1234_5678, 4'hF, SIZE_WORD,
                         0, 0, 2, 0, 0, 0, RESP_OKAY), expStall: 5};
        tbl[2] = '{r: mk(0, 32'h0000_3000, 0, 0, SIZE_WORD, 5, 0, 0, 0, 0,
                         32'h0BAD_F00D, RESP_OKAY), expStall: 8};
        tbl[3] = '{r: mk(1, 32'h0000_4002, 32'h0000_ABCD, 4'b1100, SIZE_HALF,
                         0, 0, 0, 3, 1, 0, RESP_OKAY), expStall: 7};
        tbl[4] = '{r: mk(1, 32'h0000_5000, 32'hAAAA_5555, 4'hF, SIZE_WORD,
                         0, 0, 0, 0, 0, 0, RESP_SLVERR), expStall: 3};
        tbl[5] = '{r: mk(0, 32'h0000_6000, 0, 0, SIZE_WORD, 0, 2, 0, 0, 0,
                         32'hCAFE_F00D, RESP_DECERR), expStall: 5};
        tbl[6] = '{r: mk(0, 32'h0000_1003, 0, 0, SIZE_BYTE, 1, 1, 0, 0, 0,
                         32'h0000_0077, RESP_OKAY), expStall: 5};

        repeat (3) @(negedge clk);
        #1;
        check("reset valids", 32'({axi.arvalid, axi.rready, axi.awvalid,
                                   axi.wvalid, axi.bready}), 32'd0);
        check("reset rdataM", rdataM, 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        check("reset stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        check("idle stall", 32'(mem_stall), 32'd0);

        for (int i = 0; i < 7; i++)
            doAndVerify($sformatf("vec%0d", i), tbl[i].r, tbl[i].expStall, 1'b0);

        // Back-to-back: memenM stays high across DONE.
        doAndVerify("b2b load", mk(0, 32'h0000_7000, 0, 0, SIZE_WORD, 0, 0, 0, 0, 0,
                                   32'h1111_2222, RESP_OKAY), 3, 1'b1);
        doAndVerify("b2b store", mk(1, 32'h0000_7004, 32'h3333_4444, 4'hF, SIZE_WORD,
                                    0, 0, 0, 0, 0, 0, RESP_OKAY), 3, 1'b0);

        // Reset while waiting for the read beat.
        begin
            int n;
            @(negedge clk);
            arW = 0; rW = 20; rdataV = 32'h5555_AAAA; respV = RESP_OKAY;
            memenM = 1; memwriteM = 0; addrM = 32'h0000_8000; sizeM = SIZE_WORD;
            #1;
            n = 0;
            while (!axi.rready && n < 20) begin @(negedge clk); #1; n++; end
            check("rst reach RD_R", 32'(axi.rready), 32'd1);
            rst = 0;
            #1;
            check("rst valids", 32'({axi.arvalid, axi.rready, axi.awvalid,
                                     axi.wvalid, axi.bready}), 32'd0);
            check("rst rdataM", rdataM, 32'd0);
            memenM = 0;
            #1;
            check("rst idle", 32'(mem_stall), 32'd0);
            modelRd = 0;
            repeat (2) @(negedge clk);
            rst = 1;
        end

        for (int i = 0; i < 40; i++) begin
            reqT q;
            q = mk(1'($urandom), $urandom, $urandom, 4'($urandom),
                   2'($urandom_range(0, 2)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, 2'($urandom));
            doAndVerify($sformatf("rnd%0d", i), q, modelStall(q), 1'($urandom));
        end

        @(negedge clk);
        memenM = 0;
        @(negedge clk);
        #1;
        check("final bus_err", 32'(bus_err), 32'd0);
        check("protocol fields", 32'(protErr), 32'd0);
        check("valid stability", 32'(stabErr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
